// File: rtl/pwm_carrier_sequencer_if.sv
// rtl/pwm_carrier_sequencer_if.sv - host duty-write port for the PWM carrier sequencer
interface pwm_carrier_sequencer_if #(
    parameter int CW  = 6,
    parameter int CHW = 1
);
    logic           cfg_valid;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_duty;
    logic           cfg_err;

    modport master (output cfg_valid, cfg_ch, cfg_duty, input cfg_ready, cfg_err);
    modport slave  (input cfg_valid, cfg_ch, cfg_duty, output cfg_ready, cfg_err);
endinterface

// File: rtl/pwm_carrier_sequencer.sv
// rtl/pwm_carrier_sequencer.sv - run/stop sequencer and valley-synchronous duty commit
module pwm_carrier_sequencer #(
    parameter int CW  = 6,
    parameter int NCH = 2,
    parameter int CHW = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    input  logic [CW-1:0]             carrier,
    output logic                      carrier_hold,
    pwm_carrier_sequencer_if.slave    cfg,
    output logic                      commit,
    output logic                      running,
    output logic [NCH-1:0]            pwm_out
);
    typedef enum logic [1:0] {IDLE, ARMED, RUN, STOPPING} state_t;

    state_t         state, next_state;
    logic [CW-1:0]  shadow [NCH];
    logic [CW-1:0]  active [NCH];
    logic           pending;
    logic           err_q;
    logic           valley;
    logic           accept;
    logic           ch_ok;
    logic           do_commit;
    logic [CHW-1:0] ch;

    assign ch        = cfg.cfg_ch;
    // carrier==0 is only a real valley while the generator is free-running
    assign valley    = (carrier == '0) && !carrier_hold;
    assign accept    = cfg.cfg_valid && !valley;
    assign ch_ok     = int'(ch) < NCH;
    assign do_commit = valley && pending && (state != IDLE);

    assign cfg.cfg_ready = !valley;
    assign cfg.cfg_err   = err_q;
    assign running       = (state == RUN) || (state == STOPPING);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start && !stop) next_state = ARMED;
            ARMED:    if (stop) next_state = IDLE;
                      else if (valley) next_state = RUN;
            RUN:      if (stop) next_state = STOPPING;
            STOPPING: if (valley) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            carrier_hold <= 1'b1;
            pending      <= 1'b0;
            commit       <= 1'b0;
            err_q        <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            state        <= next_state;
            carrier_hold <= (next_state == IDLE);
            commit       <= do_commit;
            err_q        <= accept && !ch_ok;
            // accept and do_commit are mutually exclusive because ready drops on the valley
            if (accept && ch_ok) begin
                pending <= 1'b1;
                for (int i = 0; i < NCH; i++)
                    if (int'(ch) == i) shadow[i] <= cfg.cfg_duty;
            end else if (do_commit) begin
                pending <= 1'b0;
                for (int i = 0; i < NCH; i++)
                    active[i] <= shadow[i];
            end
        end
    end

    always_comb begin
        pwm_out = '0;
        for (int i = 0; i < NCH; i++)
            pwm_out[i] = running && (carrier < active[i]);
    end
endmodule

// File: tb/tb_pwm_carrier_sequencer.sv
// tb/tb_pwm_carrier_sequencer.sv - bench for pwm_carrier_sequencer with triangle generator and reference model
module tb_pwm_carrier_sequencer;
    localparam int CW = 6, NCH = 2, CHW = 2, CMAX = 63;
    localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_STOP = 3;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
    logic [CW-1:0] carrier = 6'(CMAX);
    logic up = 1'b0;
    logic carrier_hold, commit, running;
    logic [NCH-1:0] pwm_out;
    int checks = 0, failures = 0;

    pwm_carrier_sequencer_if #(.CW(CW), .CHW(CHW)) cif ();

    pwm_carrier_sequencer #(.CW(CW), .NCH(NCH), .CHW(CHW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .carrier(carrier),
        .carrier_hold(carrier_hold), .cfg(cif), .commit(commit),
        .running(running), .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    // triangular generator: held at CMAX, then 62..0..63..0 with a 126-cycle period
    always @(posedge clk) begin
        if (carrier_hold) begin
            carrier <= 6'(CMAX);
            up      <= 1'b0;
        end else if (!up) begin
            if (carrier == 0) begin up <= 1'b1; carrier <= 6'd1; end
            else carrier <= carrier - 6'd1;
        end else begin
            if (carrier == 6'(CMAX)) begin up <= 1'b0; carrier <= 6'(CMAX - 1); end
            else carrier <= carrier + 6'd1;
        end
    end

    // reference model
    int m_state, m_duty_sh [NCH], m_duty_act [NCH];
    bit m_hold, m_pending, m_commit, m_err;
    bit e_valley, e_ready, e_running;
    logic [NCH-1:0] e_pwm;

    always_comb begin
        e_valley  = (carrier == 0) && !m_hold;
        e_ready   = !e_valley;
        e_running = (m_state == M_RUN) || (m_state == M_STOP);
        for (int i = 0; i < NCH; i++)
            e_pwm[i] = e_running && (int'(carrier) < m_duty_act[i]);
    end

    function automatic int next_mode(int s, bit st, bit sp, bit vly);
        if (s == M_IDLE)  return (st && !sp) ? M_ARMED : M_IDLE;
        if (s == M_ARMED) return sp ? M_IDLE : (vly ? M_RUN : M_ARMED);
        if (s == M_RUN)   return sp ? M_STOP : M_RUN;
        return vly ? M_IDLE : M_STOP;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state <= M_IDLE; m_hold <= 1'b1; m_pending <= 1'b0;
            m_commit <= 1'b0; m_err <= 1'b0;
            for (int i = 0; i < NCH; i++) begin m_duty_sh[i] <= 0; m_duty_act[i] <= 0; end
        end else begin
            m_state  <= next_mode(m_state, start, stop, e_valley);
            m_hold   <= next_mode(m_state, start, stop, e_valley) == M_IDLE;
            m_commit <= e_valley && m_pending && (m_state != M_IDLE);
            m_err    <= cif.cfg_valid && e_ready && (int'(cif.cfg_ch) >= NCH);
            if (cif.cfg_valid && e_ready && int'(cif.cfg_ch) < NCH) begin
                m_duty_sh[int'(cif.cfg_ch)] <= int'(cif.cfg_duty);
                m_pending <= 1'b1;
            end else if (e_valley && m_pending && (m_state != M_IDLE)) begin
                m_duty_act <= m_duty_sh;
                m_pending  <= 1'b0;
            end
        end
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        chk("hold", int'(carrier_hold), int'(m_hold));
        chk("running", int'(running), int'(e_running));
        chk("commit", int'(commit), int'(m_commit));
        chk("err", int'(cif.cfg_err), int'(m_err));
        chk("ready", int'(cif.cfg_ready), int'(e_ready));
        chk("pwm", int'(pwm_out), int'(e_pwm));
    endtask

    task automatic wr(int ch, int duty);
        cif.cfg_valid = 1'b1; cif.cfg_ch = 2'(ch); cif.cfg_duty = 6'(duty);
        cycle();
        cif.cfg_valid = 1'b0;
    endtask

    function automatic int hi_cycles(int d);
        return (d == 0) ? 0 : 2 * d - 1;
    endfunction

    task automatic wait_commit();
        int n = 0;
        while (commit !== 1'b1 && n < 300) begin cycle(); n++; end
        chk("commit_timeout", int'(commit), 1);
    endtask

    task automatic count_period(int exp0, int exp1, bit mid_write);
        int c0 = 0, c1 = 0;
        for (int k = 0; k < 126; k++) begin
            if (k > 0) cycle();
            c0 += int'(pwm_out[0]); c1 += int'(pwm_out[1]);
            if (k == 125) chk("ready_valley", int'(cif.cfg_ready), 0);
            if (mid_write && k == 40) begin
                cif.cfg_valid = 1'b1; cif.cfg_ch = 2'd0; cif.cfg_duty = 6'd40;
            end
            if (k == 41) cif.cfg_valid = 1'b0;
        end
        chk("pwm0_high", c0, exp0);
        chk("pwm1_high", c1, exp1);
    endtask

    typedef struct {
        bit st, sp, v; int ch, duty;
        bit e_hold, e_run, e_err, e_ready;
    } vec_t;
    vec_t vt [7];

    initial begin
        int n;
        cif.cfg_valid = 1'b0; cif.cfg_ch = '0; cif.cfg_duty = '0;
        vt[0] = '{0,0,0,0,0,  1,0,0,1};
        vt[1] = '{0,0,1,0,16, 1,0,0,1};
        vt[2] = '{0,0,1,3,5,  1,0,1,1};
        vt[3] = '{0,0,1,1,48, 1,0,0,1};
        vt[4] = '{1,1,0,0,0,  1,0,0,1};
        vt[5] = '{1,0,0,0,0,  0,0,0,1};
        vt[6] = '{0,0,0,0,0,  0,0,0,1};

        cycle(); cycle();
        chk("rst_hold", int'(carrier_hold), 1);
        chk("rst_ready", int'(cif.cfg_ready), 1);
        chk("rst_pwm", int'(pwm_out), 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            start = vt[i].st; stop = vt[i].sp; cif.cfg_valid = vt[i].v;
            cif.cfg_ch = 2'(vt[i].ch); cif.cfg_duty = 6'(vt[i].duty);
            cycle();
            chk("vec_hold", int'(carrier_hold), int'(vt[i].e_hold));
            chk("vec_run", int'(running), int'(vt[i].e_run));
            chk("vec_err", int'(cif.cfg_err), int'(vt[i].e_err));
            chk("vec_ready", int'(cif.cfg_ready), int'(vt[i].e_ready));
        end
        start = 0; stop = 0; cif.cfg_valid = 0;

        // first valley commits the IDLE writes and starts running
        wait_commit();
        chk("run_at_commit", int'(running), 1);
        count_period(hi_cycles(16), hi_cycles(48), 1'b1);
        cycle();
        chk("commit_after_valley", int'(commit), 1);

        wr(0, 5); wr(0, 9); wr(3, 1);
        chk("err_bad_ch", int'(cif.cfg_err), 1);
        wait_commit();
        count_period(hi_cycles(9), hi_cycles(48), 1'b0);

        n = 0;
        while (!(carrier == 6'd30 && !up) && n < 300) begin cycle(); n++; end
        chk("reach_30_desc", int'(carrier), 30);
        stop = 1'b1; cycle(); stop = 1'b0;
        n = 0;
        while (carrier_hold !== 1'b1 && n < 300) begin
            chk("stopping_running", int'(running), 1);
            cycle(); n++;
        end
        chk("stop_hold", int'(carrier_hold), 1);
        chk("stop_running", int'(running), 0);
        chk("stop_pwm", int'(pwm_out), 0);
        start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0; cycle();
        chk("start_stop_idle", int'(carrier_hold), 1);

        start = 1'b1; cycle(); start = 1'b0;
        n = 0;
        while (running !== 1'b1 && n < 300) begin cycle(); n++; end
        wr(1, 20);
        repeat (5) cycle();
        #2 rst = 1'b1;
        #1;
        chk("arst_hold", int'(carrier_hold), 1);
        chk("arst_running", int'(running), 0);
        chk("arst_pwm", int'(pwm_out), 0);
        chk("arst_ready", int'(cif.cfg_ready), 1);
        cycle(); cycle();
        rst = 1'b0;
        start = 1'b1; cycle(); start = 1'b0;
        n = 0;
        while (running !== 1'b1 && n < 300) begin cycle(); n++; end
        chk("restart_running", int'(running), 1);
        chk("restart_no_commit", int'(commit), 0);

        for (int i = 0; i < 3000; i++) begin
            start = ($urandom % 20) == 0;
            stop  = ($urandom % 60) == 0;
            cif.cfg_valid = ($urandom % 3) == 0;
            cif.cfg_ch    = 2'($urandom % 4);
            cif.cfg_duty  = 6'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
